// File: rtl/yi_writer.sv
`timescale 1ns/1ps
// yi_writer: AXI4 INCR burst master writing the 256-bit Y stream to the Y region; YI_WRITER_PERF_EN adds a W-phase stall counter.
// Latency: one CALC cycle plus the AW handshake per burst; W data is a zero-latency pass-through of the stream.
// Backpressure: s_ready follows wready only during a burst's W phase; one burst outstanding at a time.

module yi_writer #(
  parameter logic [31:0] YVAL_BASE_ADDR = 32'h40000000,
  parameter int          MAX_BURST      = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         Write_Begin,
  input  logic [31:0]  Write_Length,
  output logic         Write_Done,
  output logic         Write_Error,
  output logic [31:0]  Stall_Cycles,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [255:0] s_data,
  output logic         m_axi_Y_awid,
  output logic [47:0]  m_axi_Y_awaddr,
  output logic [7:0]   m_axi_Y_awlen,
  output logic [2:0]   m_axi_Y_awsize,
  output logic [1:0]   m_axi_Y_awburst,
  output logic         m_axi_Y_awlock,
  output logic [3:0]   m_axi_Y_awcache,
  output logic [2:0]   m_axi_Y_awprot,
  output logic [3:0]   m_axi_Y_awqos,
  output logic         m_axi_Y_awvalid,
  input  logic         m_axi_Y_awready,
  output logic [255:0] m_axi_Y_wdata,
  output logic [31:0]  m_axi_Y_wstrb,
  output logic         m_axi_Y_wlast,
  output logic         m_axi_Y_wvalid,
  input  logic         m_axi_Y_wready,
  input  logic         m_axi_Y_bid,
  input  logic [1:0]   m_axi_Y_bresp,
  input  logic         m_axi_Y_bvalid,
  output logic         m_axi_Y_bready
);

  localparam logic [47:0] BASE_ADDR = {16'h0000, YVAL_BASE_ADDR};
  localparam logic [7:0]  MAX_B     = 8'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, CALC, AW, W, B, DONE} state_t;

  state_t      state_q;
  logic [31:0] remaining_q;
  logic [47:0] addr_q;
  logic [7:0]  beats_q;
  logic [7:0]  awlen_q;
  logic [7:0]  beat_cnt_q;
  logic        awvalid_q;
  logic        in_w_q;
  logic        last_q;
  logic        bready_q;
  logic        done_q;
  logic        err_q;

  logic [7:0]  room;
  logic [7:0]  cap;
  logic [7:0]  beats_c;
  logic        unused_bid;

  assign unused_bid = m_axi_Y_bid;

  // Beats left before the next 4 KB page: 128 slots of 32 B per page.
  always_comb begin
    room    = 8'd128 - {1'b0, addr_q[11:5]};
    cap     = (MAX_B < room) ? MAX_B : room;
    beats_c = (remaining_q < {24'd0, cap}) ? remaining_q[7:0] : cap;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= BASE_ADDR;
      beats_q     <= '0;
      awlen_q     <= '0;
      beat_cnt_q  <= '0;
      awvalid_q   <= 1'b0;
      in_w_q      <= 1'b0;
      last_q      <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Write_Begin) begin
            remaining_q <= Write_Length;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
            state_q     <= (Write_Length == 32'd0) ? DONE : CALC;
          end
        end
        CALC: begin
          beats_q   <= beats_c;
          awlen_q   <= beats_c - 8'd1;
          awvalid_q <= 1'b1;
          state_q   <= AW;
        end
        AW: begin
          if (m_axi_Y_awready) begin
            awvalid_q  <= 1'b0;
            in_w_q     <= 1'b1;
            beat_cnt_q <= '0;
            last_q     <= (awlen_q == 8'd0);
            state_q    <= W;
          end
        end
        W: begin
          if (s_valid && m_axi_Y_wready) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            last_q     <= (beat_cnt_q + 8'd1 == awlen_q);
            if (last_q) begin
              in_w_q   <= 1'b0;
              last_q   <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= B;
            end
          end
        end
        B: begin
          if (m_axi_Y_bvalid) begin
            bready_q    <= 1'b0;
            if (m_axi_Y_bresp != 2'b00) err_q <= 1'b1;
            remaining_q <= remaining_q - {24'd0, beats_q};
            addr_q      <= addr_q + {35'd0, beats_q, 5'd0};
            state_q     <= (remaining_q == {24'd0, beats_q}) ? DONE : CALC;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef YI_WRITER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (state_q == IDLE && Write_Begin) begin
      stall_q <= '0;
    end else if (state_q == W && !s_valid && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign Stall_Cycles = stall_q;
`else
  assign Stall_Cycles = '0;
`endif

  assign m_axi_Y_awid    = 1'b0;
  assign m_axi_Y_awaddr  = addr_q;
  assign m_axi_Y_awlen   = awlen_q;
  assign m_axi_Y_awsize  = 3'b101;
  assign m_axi_Y_awburst = 2'b01;
  assign m_axi_Y_awlock  = 1'b0;
  assign m_axi_Y_awcache = 4'b0011;
  assign m_axi_Y_awprot  = 3'b000;
  assign m_axi_Y_awqos   = 4'b0000;
  assign m_axi_Y_awvalid = awvalid_q;

  assign m_axi_Y_wdata   = s_data;
  assign m_axi_Y_wstrb   = '1;
  assign m_axi_Y_wlast   = last_q;
  assign m_axi_Y_wvalid  = in_w_q & s_valid;
  assign s_ready         = in_w_q & m_axi_Y_wready;

  assign m_axi_Y_bready  = bready_q;
  assign Write_Done      = done_q;
  assign Write_Error     = err_q;

endmodule

// File: tb/tb_yi_writer.sv
`timescale 1ns/1ps
// Directed bench for yi_writer: transfer table, zero length, 4 KB split, mid-burst reset, stall counter.

module tb_yi_writer;

  localparam logic [47:0] BASE = 48'h0000_4000_0000;
`ifdef YI_WRITER_PERF_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         Write_Begin  = 1'b0;
  logic [31:0]  Write_Length = 32'd0;
  logic         Write_Done, Write_Error;
  logic [31:0]  Stall_Cycles;
  logic         s_valid = 1'b1;
  logic         s_ready;
  logic [255:0] s_data  = '0;
  logic         awid, awlock, awvalid;
  logic [47:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst;
  logic [3:0]   awcache, awqos;
  logic         awready = 1'b1;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b1;
  logic         bid    = 1'b0;
  logic [1:0]   bresp  = 2'b00;
  logic         bvalid = 1'b1;
  logic         bready;

  yi_writer dut (
    .clk(clk), .rstn(rstn), .Write_Begin(Write_Begin), .Write_Length(Write_Length),
    .Write_Done(Write_Done), .Write_Error(Write_Error), .Stall_Cycles(Stall_Cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_axi_Y_awid(awid), .m_axi_Y_awaddr(awaddr), .m_axi_Y_awlen(awlen), .m_axi_Y_awsize(awsize),
    .m_axi_Y_awburst(awburst), .m_axi_Y_awlock(awlock), .m_axi_Y_awcache(awcache),
    .m_axi_Y_awprot(awprot), .m_axi_Y_awqos(awqos), .m_axi_Y_awvalid(awvalid),
    .m_axi_Y_awready(awready), .m_axi_Y_wdata(wdata), .m_axi_Y_wstrb(wstrb),
    .m_axi_Y_wlast(wlast), .m_axi_Y_wvalid(wvalid), .m_axi_Y_wready(wready),
    .m_axi_Y_bid(bid), .m_axi_Y_bresp(bresp), .m_axi_Y_bvalid(bvalid), .m_axi_Y_bready(bready)
  );

  // Second instance placed just below a 4 KB page boundary, always-ready slave.
  logic         begin2 = 1'b0;
  logic [31:0]  len2   = 32'd0;
  logic         done2, err2, s_ready2, awid2, awlock2, awvalid2, wlast2, wvalid2, bready2;
  logic [31:0]  stall2, wstrb2;
  logic [47:0]  awaddr2;
  logic [7:0]   awlen2;
  logic [2:0]   awsize2, awprot2;
  logic [1:0]   awburst2;
  logic [3:0]   awcache2, awqos2;
  logic [255:0] wdata2;

  yi_writer #(.YVAL_BASE_ADDR(32'h40000FA0), .MAX_BURST(16)) dut2 (
    .clk(clk), .rstn(rstn), .Write_Begin(begin2), .Write_Length(len2),
    .Write_Done(done2), .Write_Error(err2), .Stall_Cycles(stall2),
    .s_valid(1'b1), .s_ready(s_ready2), .s_data(256'd0),
    .m_axi_Y_awid(awid2), .m_axi_Y_awaddr(awaddr2), .m_axi_Y_awlen(awlen2), .m_axi_Y_awsize(awsize2),
    .m_axi_Y_awburst(awburst2), .m_axi_Y_awlock(awlock2), .m_axi_Y_awcache(awcache2),
    .m_axi_Y_awprot(awprot2), .m_axi_Y_awqos(awqos2), .m_axi_Y_awvalid(awvalid2),
    .m_axi_Y_awready(1'b1), .m_axi_Y_wdata(wdata2), .m_axi_Y_wstrb(wstrb2),
    .m_axi_Y_wlast(wlast2), .m_axi_Y_wvalid(wvalid2), .m_axi_Y_wready(1'b1),
    .m_axi_Y_bid(1'b0), .m_axi_Y_bresp(2'b00), .m_axi_Y_bvalid(1'b1), .m_axi_Y_bready(bready2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkword(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'hC0DE_0000;
    return {w + 32'd7, w + 32'd6, w + 32'd5, w + 32'd4, w + 32'd3, w + 32'd2, w + 32'd1, w};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stream source and AXI slave: inputs change 2 ns after the rising edge.
  bit   bp_en     = 1'b0;
  logic sv_hold   = 1'b1;
  int   sidx      = 0;
  int   b_total   = 0;
  int   b_start   = 0;
  int   err_burst = -1;
  bit   s_hs, b_hs;

  always begin
    @(negedge clk);
    s_hs = rstn && s_valid && s_ready;
    b_hs = rstn && bvalid && bready;
    @(posedge clk);
    #2;
    if (s_hs) sidx++;
    if (b_hs) b_total++;
    s_data = mkword(sidx);
    if (bp_en) begin
      if (!s_valid || s_hs) s_valid = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      bvalid  = 1'($urandom_range(0, 1));
    end else begin
      s_valid = sv_hold;
      awready = 1'b1;
      wready  = 1'b1;
      bvalid  = 1'b1;
    end
    bresp = (b_total - b_start == err_burst) ? 2'b10 : 2'b00;
  end

  // Bus monitor: records handshakes and checks ordering and stability.
  logic [47:0]  aq[$];
  logic [7:0]   lq[$];
  logic [255:0] wq[$];
  logic [47:0]  aq2[$];
  logic [7:0]   lq2[$];
  int           done_cnt = 0, w2_cnt = 0, last2_cnt = 0, done2_cnt = 0, beat = 0;
  bit           aw_ok = 1'b0, aw_st = 1'b0, w_st = 1'b0;
  logic [55:0]  aw_prev = '0;
  logic [255:0] w_prev_data = '0;
  logic         w_prev_last = 1'b0;
  logic [7:0]   cur_len = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      aw_ok = 1'b0;
      aw_st = 1'b0;
      w_st  = 1'b0;
    end else begin
      if (aw_st) chk("aw_hold", 64'({awvalid, awaddr, awlen}), 64'({1'b1, aw_prev}));
      if (w_st) begin
        chk("w_hold_ctl", 64'({wvalid, wlast}), 64'({1'b1, w_prev_last}));
        chkw("w_hold_data", wdata, w_prev_data);
      end
      if (wvalid || s_ready) chk("w_after_aw", 64'(aw_ok), 64'd1);
      aw_st       = awvalid && !awready;
      aw_prev     = {awaddr, awlen};
      w_st        = wvalid && !wready;
      w_prev_data = wdata;
      w_prev_last = wlast;
      if (awvalid && awready) begin
        aq.push_back(awaddr);
        lq.push_back(awlen);
        cur_len = awlen;
        beat    = 0;
        aw_ok   = 1'b1;
      end
      if (wvalid && wready) begin
        wq.push_back(wdata);
        chk("wlast_pos", 64'(wlast), 64'(beat == int'(cur_len)));
        beat++;
        if (wlast) aw_ok = 1'b0;
      end
      if (Write_Done) done_cnt++;
      if (awvalid2) begin
        aq2.push_back(awaddr2);
        lq2.push_back(awlen2);
      end
      if (wvalid2) begin
        w2_cnt++;
        if (wlast2) last2_cnt++;
      end
      if (done2) done2_cnt++;
    end
  end

  typedef struct {
    int len;
    bit bp;
    int err_b;
    int n;
    int last;
    bit err;
  } vec_t;

  task automatic wait_done(input int d0, input string name);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      cyc(1);
      k++;
    end
    chk(name, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic apply(input vec_t v);
    int a0, w0, d0, first, n;
    a0 = aq.size(); w0 = wq.size(); d0 = done_cnt; first = sidx;
    b_start = b_total; err_burst = v.err_b; bp_en = v.bp;
    Write_Length = 32'(v.len);
    Write_Begin  = 1'b1;
    cyc(1);
    Write_Begin  = 1'b0;
    wait_done(d0, "done_seen");
    bp_en = 1'b0;
    cyc(4);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    n = aq.size() - a0;
    chk("bursts", 64'(n), 64'(v.n));
    for (int i = 0; i < n && i < v.n; i++) begin
      chk("awaddr", 64'(aq[a0 + i]), 64'(BASE + 48'(i) * 48'h200));
      chk("awlen", 64'(lq[a0 + i]), 64'((i == v.n - 1) ? v.last : 15));
    end
    chk("beats", 64'(wq.size() - w0), 64'(v.len));
    for (int i = 0; i < v.len && w0 + i < wq.size(); i++)
      chkw("wdata", wq[w0 + i], mkword(first + i));
    chk("err", 64'(Write_Error), 64'(v.err));
    err_burst = -1;
  endtask

  vec_t vecs[5];
  vec_t v_post;

  initial begin
    int a0, w0, d0, k;
    vecs[0] = '{len: 40, bp: 1'b0, err_b: -1, n: 3, last: 7, err: 1'b0};
    vecs[1] = '{len: 20, bp: 1'b1, err_b: -1, n: 2, last: 3, err: 1'b0};
    vecs[2] = '{len: 33, bp: 1'b0, err_b:  1, n: 3, last: 0, err: 1'b1};
    vecs[3] = '{len:  1, bp: 1'b0, err_b: -1, n: 1, last: 0, err: 1'b0};
    vecs[4] = '{len: 17, bp: 1'b1, err_b: -1, n: 2, last: 0, err: 1'b0};

    cyc(3);
    @(negedge clk);
    chk("rst_ctl", 64'({awvalid, wvalid, wlast, bready, s_ready, Write_Done, Write_Error}), 64'd0);
    chk("rst_stall", 64'(Stall_Cycles), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'(BASE));
    chk("rst_awlen", 64'(awlen), 64'd0);
    chk("const_aw", 64'({awid, awsize, awburst, awlock, awcache, awprot, awqos}),
        64'({1'b0, 3'b101, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000}));
    chk("const_wstrb", 64'(wstrb), 64'(32'hFFFF_FFFF));
    cyc(1);
    rstn = 1'b1;
    cyc(2);

    for (int i = 0; i < 5; i++) apply(vecs[i]);

    // Zero length: no AW, Write_Done two cycles after the start pulse.
    a0 = aq.size();
    Write_Length = 32'd0;
    Write_Begin  = 1'b1;
    @(negedge clk); chk("zero_d0", 64'(Write_Done), 64'd0);
    cyc(1); Write_Begin = 1'b0;
    @(negedge clk); chk("zero_d1", 64'(Write_Done), 64'd0);
    cyc(1);
    @(negedge clk); chk("zero_d2", 64'(Write_Done), 64'd1);
    cyc(1);
    @(negedge clk); chk("zero_d3", 64'(Write_Done), 64'd0);
    chk("zero_no_aw", 64'(aq.size() - a0), 64'd0);
    cyc(2);

    // Base 0x40000FA0: 3 beats up to the page edge, then 7 from 0x40001000.
    d0 = done2_cnt;
    len2 = 32'd10; begin2 = 1'b1; cyc(1); begin2 = 1'b0;
    k = 0;
    while (done2_cnt == d0 && k < 500) begin cyc(1); k++; end
    cyc(2);
    chk("pg_done", 64'(done2_cnt - d0), 64'd1);
    chk("pg_bursts", 64'(aq2.size()), 64'd2);
    if (aq2.size() >= 2) begin
      chk("pg_addr0", 64'(aq2[0]), 64'h4000_0FA0);
      chk("pg_len0", 64'(lq2[0]), 64'd2);
      chk("pg_addr1", 64'(aq2[1]), 64'h4000_1000);
      chk("pg_len1", 64'(lq2[1]), 64'd6);
    end
    chk("pg_beats", 64'(w2_cnt), 64'd10);
    chk("pg_lasts", 64'(last2_cnt), 64'd2);

    // Reset during W of the second burst.
    a0 = aq.size(); w0 = wq.size();
    Write_Length = 32'd40; Write_Begin = 1'b1; cyc(1); Write_Begin = 1'b0;
    k = 0;
    while (!(aq.size() >= a0 + 2 && wq.size() >= w0 + 18) && k < 500) begin cyc(1); k++; end
    chk("rst_mid_reach", 64'(aq.size() >= a0 + 2 && wq.size() >= w0 + 18), 64'd1);
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctl", 64'({awvalid, wvalid, wlast, bready, s_ready, Write_Done}), 64'd0);
    chk("rst_mid_awaddr", 64'(awaddr), 64'(BASE));
    cyc(1);
    v_post = '{len: 3, bp: 1'b0, err_b: -1, n: 1, last: 2, err: 1'b0};
    apply(v_post);

    // Five W cycles with the stream empty.
    a0 = aq.size(); d0 = done_cnt;
    sv_hold = 1'b0;
    Write_Length = 32'd2; Write_Begin = 1'b1; cyc(1); Write_Begin = 1'b0;
    k = 0;
    while (aq.size() == a0 && k < 100) begin cyc(1); k++; end
    chk("stall_aw", 64'(aq.size() > a0), 64'd1);
    cyc(5);
    sv_hold = 1'b1;
    wait_done(d0, "stall_done");
    cyc(3);
    chk("stall_cnt", 64'(Stall_Cycles), 64'(STALL_EXP));
    v_post = '{len: 1, bp: 1'b0, err_b: -1, n: 1, last: 0, err: 1'b0};
    apply(v_post);
    chk("stall_clear", 64'(Stall_Cycles), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/yi_writer.md
Name: yi_writer

Overview:
- AXI4 burst write master that drains the 256-bit packed Y result stream leaving the row kernel and writes it to the Y vector region in device memory.
- Write-side counterpart of the colIndex/Xi read masters in the SpMV kernel.
- Software arms it with a start pulse and a beat count.
- It reports completion and response errors back to the control logic.

Parameters:
- YVAL_BASE_ADDR, 32'h40000000, byte address of Y[0]; must be 32-byte aligned.
- MAX_BURST, 16, maximum beats per AW burst; legal range 1..128.

Ports:
- clk  input  1  kernel clock
- rstn  input  1  synchronous active-low reset
- Write_Begin  input  1  one-cycle start pulse; sampled only in IDLE
- Write_Length  input  32  number of 256-bit beats to write; latched on Write_Begin
- Write_Done  output  1  one-cycle pulse when the final B response has been received
- Write_Error  output  1  sticky; set on any BRESP != 0; cleared by the next accepted Write_Begin
- Stall_Cycles  output  32  count of W-state cycles with s_valid=0 (see optional feature)
- s_valid / s_ready / s_data  in/out/in  1/1/256  Y stream from the row kernel (valid/ready)
- m_axi_Y_awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos  output  1/48/8/3/2/1/4/3/4  AW channel
- m_axi_Y_awvalid out 1; m_axi_Y_awready in 1
- m_axi_Y_wdata out 256; m_axi_Y_wstrb out 32; m_axi_Y_wlast out 1; m_axi_Y_wvalid out 1; m_axi_Y_wready in 1
- m_axi_Y_bid in 1; m_axi_Y_bresp in 2; m_axi_Y_bvalid in 1; m_axi_Y_bready out 1

Behaviour:
- Constant outputs: awid=0, awsize=3'b101 (32 B), awburst=2'b01 (INCR), awlock=0, awcache=4'b0011, awprot=0, awqos=0, wstrb=all ones.
- Reset values: awvalid, wvalid, wlast, bready, s_ready, Write_Done, Write_Error and Stall_Cycles all 0; awaddr=YVAL_BASE_ADDR; awlen=0; state=IDLE.
- Reset mid-operation: abandon the transfer; return to IDLE with all valids low. No attempt is made to complete an outstanding burst.
- FSM states: IDLE, CALC, AW, W, B, DONE.
- IDLE:
  - Write_Begin=1: latch remaining=Write_Length, set addr=YVAL_BASE_ADDR, clear Write_Error.
  - If Write_Length=0, go to DONE; otherwise go to CALC.
  - Write_Begin in any other state is ignored.
- CALC (1 cycle):
  - beats = min(remaining, MAX_BURST, 128 - addr[11:5]), so no burst crosses a 4 KB boundary.
  - awlen = beats-1; go to AW.
- AW: awvalid=1, held stable until awready. On the handshake, go to W with beat_cnt=0.
- W:
  - wvalid=s_valid, s_ready=wready, wdata=s_data (pure pass-through, zero latency).
  - wlast=1 when beat_cnt==awlen.
  - Each handshake increments beat_cnt.
  - The handshake with wlast goes to B.
  - W data is never issued before the AW handshake.
- B: bready=1. On bvalid:
  - bresp != 0 sets Write_Error.
  - remaining -= beats; addr += beats*32.
  - If remaining=0, go to DONE; otherwise go to CALC.
- DONE: Write_Done=1 for exactly one cycle; go to IDLE.
- Only one burst is outstanding at a time; no AW/W overlap across bursts.
- Width rules:
  - remaining is 32 bits.
  - addr is 48 bits and wraps modulo 2^48 with no error.
  - beats is 8 bits, range 1..128.
- Stream data is never dropped: s_ready is 0 outside W.

Optional Feature:
- Macro: YI_WRITER_PERF_EN.
- Defined:
  - Stall_Cycles counts cycles in W with s_valid=0.
  - It is cleared by an accepted Write_Begin and saturates at 32'hFFFFFFFF.
- Undefined: Stall_Cycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- MAX_BURST=16, Write_Length=40, awready/wready/bvalid always 1, continuous stream -> three bursts: awaddr 0x40000000/0x40000200/0x40000400, awlen 15/15/7; wlast on beats 16/32/40; one Write_Done pulse.
- YVAL_BASE_ADDR=0x40000FA0, Write_Length=10 -> burst 1 awlen=2 (3 beats to the 4 KB boundary), burst 2 at awaddr 0x40001000 with awlen=6.
- Write_Length=0 -> no awvalid, Write_Done pulses 2 cycles after Write_Begin.
- Random wready/awready/s_valid backpressure, Write_Length=20 -> all 20 data words appear on wdata in order; AW/W signals stay stable while stalled.
- Second B response returns bresp=2'b10 -> Write_Error=1 and remains 1 after Write_Done; the next Write_Begin clears it.
- rstn=0 for 1 cycle during the W state of burst 2 -> all valids 0 next cycle, state IDLE. With YI_WRITER_PERF_EN defined: 5 s_valid=0 W-cycles give Stall_Cycles=5.
